// File: rtl/dma_arb_pkg.sv
// ---------------------------------------------------------------------------
// dma_arb_pkg
// Shared types and helpers for the DMA bus arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, DRAIN)
//   cnt_width() : bit width needed to hold the values 0..max_val inclusive
// ---------------------------------------------------------------------------
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search. Starting at (last_owner+1) and
// wrapping past NUM_REQ-1 back to 0, it returns the first requesting master.
// Ports:
//   req        in  NUM_REQ  request vector, bit i belongs to master i
//   last_owner in  IDX_W    index of the most recently granted master
//   valid      out 1        at least one request is high
//   winner     out IDX_W    index of the selected master (0 when !valid)
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  // Walk the candidates from farthest to nearest so that the nearest
  // requesting master (offset 1) is the last one written and therefore wins.
  // last_owner+k is below 2*NUM_REQ, so one conditional subtract wraps it.
  always_comb begin
    int             w_pos;
    logic [IDX_W-1:0] w_cand;
    valid  = 1'b0;
    winner = '0;
    w_pos  = 0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pos = int'(last_owner) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      w_cand = IDX_W'(w_pos);
      if (req[w_cand]) begin
        valid  = 1'b1;
        winner = w_cand;
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dma_bus_arbiter
// Round-robin owner arbitration for the shared TileLink host port. A grant is
// held until the owner drops its request, then every outstanding A request of
// that owner must see its D response before the next owner is chosen.
// Optional feature macro: ARB_TIMEOUT_EN (grant watchdog with preemption).
// Ports:
//   clk         in  1        rising-edge clock
//   rst_n       in  1        asynchronous active-low reset
//   bus_rqst    in  NUM_REQ  level request per master
//   bus_grnt    out NUM_REQ  registered one-hot/zero grant
//   grant_idx   out IDX_W    current or last owner, host mux select
//   a_fire      in  1        A channel handshake on the shared port
//   d_fire      in  1        D channel handshake on the shared port
//   bus_busy    out 1        arbiter is not IDLE
//   proto_err   out 1        sticky protocol-error flag
//   timeout_irq out 1        one-cycle watchdog pulse (0 without the macro)
// ---------------------------------------------------------------------------
module dma_bus_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         bus_rqst,
  output logic [NUM_REQ-1:0]         bus_grnt,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  input  logic                       a_fire,
  input  logic                       d_fire,
  output logic                       bus_busy,
  output logic                       proto_err,
  output logic                       timeout_irq
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int OUTS_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(MAX_OUTSTANDING);

  arb_state_e         r_state, w_state_next;
  logic [NUM_REQ-1:0] r_grnt, w_grnt_next;
  logic [IDX_W-1:0]   r_grant_idx, w_idx_next;
  logic [IDX_W-1:0]   r_last_owner, w_last_next;
  logic [IDX_W-1:0]   w_winner;
  logic               w_pick_valid;
  logic [OUTS_W-1:0]  r_outs, w_outs_next;
  logic               r_proto_err, w_err_set;
  logic               w_a_count;
  logic               w_owner_req;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (bus_rqst),
    .last_owner (r_last_owner),
    .valid      (w_pick_valid),
    .winner     (w_winner)
  );

  // Only A requests issued while a master holds the grant belong to it.
  assign w_a_count   = a_fire && (r_state == GRANT);
  assign w_owner_req = bus_rqst[r_grant_idx];

  // Outstanding-transaction bookkeeping. A simultaneous counted A and D
  // cancel out; underflow and overflow are flagged and clamped.
  always_comb begin
    w_outs_next = r_outs;
    w_err_set   = 1'b0;
    if (a_fire && !w_a_count) begin
      w_err_set = 1'b1;
    end
    if (w_a_count && !d_fire) begin
      if (r_outs == OUTS_MAX) begin
        w_err_set = 1'b1;
      end else begin
        w_outs_next = r_outs + 1'b1;
      end
    end else if (d_fire && !w_a_count) begin
      if (r_outs == '0) begin
        w_err_set = 1'b1;
      end else begin
        w_outs_next = r_outs - 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd, w_wd_next;
  logic            r_timeout_irq, w_irq_next;
  logic            w_others_req;

  assign w_others_req = |(bus_rqst & ~r_grnt);
  assign timeout_irq  = r_timeout_irq;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_irq  = 1'b0;
`endif

  // Ownership FSM. The owner's own request release takes precedence over
  // a watchdog expiry in the same cycle. DRAIN keeps grant_idx so late D
  // beats still route to the previous owner.
  always_comb begin
    w_state_next = r_state;
    w_grnt_next  = r_grnt;
    w_idx_next   = r_grant_idx;
    w_last_next  = r_last_owner;
`ifdef ARB_TIMEOUT_EN
    w_wd_next    = '0;
    w_irq_next   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grnt_next           = '0;
          w_grnt_next[w_winner] = 1'b1;
          w_idx_next            = w_winner;
          w_last_next           = w_winner;
          w_state_next          = GRANT;
        end
      end
      GRANT: begin
        if (!w_owner_req) begin
          w_grnt_next  = '0;
          w_state_next = (w_outs_next == '0) ? IDLE : DRAIN;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_others_req) begin
          if (r_wd == WD_LAST) begin
            w_irq_next   = 1'b1;
            w_grnt_next  = '0;
            w_state_next = DRAIN;
          end else begin
            w_wd_next = r_wd + 1'b1;
          end
        end
`endif
      end
      DRAIN: begin
        if (w_outs_next == '0) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_grnt_next  = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  // State and ownership registers; reset hands first priority to master 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grnt       <= '0;
      r_grant_idx  <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_outs       <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grnt       <= w_grnt_next;
      r_grant_idx  <= w_idx_next;
      r_last_owner <= w_last_next;
      r_outs       <= w_outs_next;
      r_proto_err  <= r_proto_err | w_err_set;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and its interrupt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd          <= '0;
      r_timeout_irq <= 1'b0;
    end else begin
      r_wd          <= w_wd_next;
      r_timeout_irq <= w_irq_next;
    end
  end
`endif

  assign bus_grnt  = r_grnt;
  assign grant_idx = r_grant_idx;
  assign bus_busy  = (r_state != IDLE);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_bus_arbiter
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a transaction-level ownership model of the arbiter.
// ---------------------------------------------------------------------------
module tb_dma_bus_arbiter;

  localparam int NREQ = 3;
  localparam int MAXO = 4;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] bus_rqst;
  logic            a_fire;
  logic            d_fire;
  logic [NREQ-1:0] bus_grnt;
  logic [1:0]      grant_idx;
  logic            bus_busy;
  logic            proto_err;
  logic            timeout_irq;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus, whether it is only waiting for
  // responses, and plain integer counts for outstanding work and watchdog.
  bit mOwned;
  bit mDraining;
  int mOwner;
  int mLast;
  int mOuts;
  int mWd;
  bit mErr;
  bit mIrq;

  dma_bus_arbiter #(
    .NUM_REQ         (NREQ),
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_rqst    (bus_rqst),
    .bus_grnt    (bus_grnt),
    .grant_idx   (grant_idx),
    .a_fire      (a_fire),
    .d_fire      (d_fire),
    .bus_busy    (bus_busy),
    .proto_err   (proto_err),
    .timeout_irq (timeout_irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOwned    = 1'b0;
    mDraining = 1'b0;
    mOwner    = 0;
    mLast     = NREQ - 1;
    mOuts     = 0;
    mWd       = 0;
    mErr      = 1'b0;
    mIrq      = 1'b0;
  endtask

  task automatic modelStep();
    bit aCounted;
    bit anyOther;
    int nOuts;
    aCounted = a_fire && mOwned && !mDraining;
    nOuts    = mOuts;
    if (a_fire && !aCounted) mErr = 1'b1;
    if (aCounted && !d_fire) begin
      if (mOuts == MAXO) mErr = 1'b1;
      else nOuts = mOuts + 1;
    end else if (d_fire && !aCounted) begin
      if (mOuts == 0) mErr = 1'b1;
      else nOuts = mOuts - 1;
    end
    mIrq = 1'b0;
    if (!mOwned) begin
      mWd = 0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (mLast + k) % NREQ;
        if (bus_rqst[c]) begin
          mOwner = c;
          mLast  = c;
          mOwned = 1'b1;
          break;
        end
      end
    end else if (!mDraining) begin
      if (!bus_rqst[mOwner]) begin
        mWd = 0;
        if (nOuts == 0) mOwned = 1'b0;
        else mDraining = 1'b1;
      end else begin
        anyOther = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (i != mOwner && bus_rqst[i]) anyOther = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        if (anyOther) begin
          mWd++;
          if (mWd == TMO) begin
            mIrq      = 1'b1;
            mDraining = 1'b1;
            mWd       = 0;
          end
        end else begin
          mWd = 0;
        end
`else
        mWd = 0;
`endif
      end
    end else begin
      mWd = 0;
      if (nOuts == 0) begin
        mOwned    = 1'b0;
        mDraining = 1'b0;
      end
    end
    mOuts = nOuts;
  endtask

  task automatic compareAll(input string tag);
    logic [31:0] expGrnt;
    expGrnt = (mOwned && !mDraining) ? (32'd1 << mOwner) : 32'd0;
    checkOutput({tag, "_grnt"}, 32'(bus_grnt), expGrnt);
    checkOutput({tag, "_idx"},  32'(grant_idx), 32'(mOwner));
    checkOutput({tag, "_busy"}, 32'(bus_busy), 32'(mOwned));
    checkOutput({tag, "_err"},  32'(proto_err), 32'(mErr));
    checkOutput({tag, "_irq"},  32'(timeout_irq), 32'(mIrq));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    compareAll(tag);
  endtask

  task automatic applyStimulus(input string tag, input logic [NREQ-1:0] req, input logic a, input logic d);
    bus_rqst = req;
    a_fire   = a;
    d_fire   = d;
    tick(tag);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int irqCount;
    bit sawGrant1;
    logic [NREQ-1:0] reqState;
    logic a;
    logic d;

    rst_n    = 1'b0;
    bus_rqst = '0;
    a_fire   = 1'b0;
    d_fire   = 1'b0;
    doReset();

    // Two requesters: master 0 first, one bubble, then master 1.
    applyStimulus("rr0", 3'b011, 1'b0, 1'b0);
    checkOutput("first_grant", 32'(bus_grnt), 32'h1);
    applyStimulus("rr1", 3'b011, 1'b0, 1'b0);
    applyStimulus("rr2", 3'b010, 1'b0, 1'b0);
    checkOutput("bubble", 32'(bus_grnt), 32'h0);
    applyStimulus("rr3", 3'b010, 1'b0, 1'b0);
    checkOutput("second_grant", 32'(bus_grnt), 32'h2);

    // Three A requests, release, three spaced D responses through DRAIN.
    repeat (3) applyStimulus("aq", 3'b010, 1'b1, 1'b0);
    applyStimulus("drop", 3'b000, 1'b0, 1'b0);
    checkOutput("drain_busy", 32'(bus_busy), 32'h1);
    applyStimulus("dr1", 3'b000, 1'b0, 1'b1);
    applyStimulus("dr2", 3'b000, 1'b0, 1'b0);
    applyStimulus("dr3", 3'b000, 1'b0, 1'b1);
    applyStimulus("dr4", 3'b000, 1'b0, 1'b0);
    checkOutput("drain_idx", 32'(grant_idx), 32'h1);
    checkOutput("drain_grnt", 32'(bus_grnt), 32'h0);
    applyStimulus("dr5", 3'b000, 1'b0, 1'b1);
    checkOutput("drain_done", 32'(bus_busy), 32'h0);

    // Simultaneous A/D keeps the count; release on the last D skips DRAIN.
    applyStimulus("sg", 3'b001, 1'b0, 1'b0);
    checkOutput("wrap_grant", 32'(bus_grnt), 32'h1);
    applyStimulus("s1", 3'b001, 1'b1, 1'b0);
    applyStimulus("s2", 3'b001, 1'b1, 1'b0);
    applyStimulus("s3", 3'b001, 1'b1, 1'b1);
    applyStimulus("s4", 3'b001, 1'b0, 1'b1);
    applyStimulus("s5", 3'b000, 1'b0, 1'b1);
    checkOutput("direct_idle", 32'(bus_busy), 32'h0);
    checkOutput("no_err", 32'(proto_err), 32'h0);

    // Overflow of the outstanding limit, then underflow in IDLE.
    doReset();
    applyStimulus("og", 3'b001, 1'b0, 1'b0);
    repeat (4) applyStimulus("ov", 3'b001, 1'b1, 1'b0);
    checkOutput("pre_ovf_err", 32'(proto_err), 32'h0);
    applyStimulus("ovf", 3'b001, 1'b1, 1'b0);
    checkOutput("ovf_err", 32'(proto_err), 32'h1);
    repeat (4) applyStimulus("ovd", 3'b001, 1'b0, 1'b1);
    checkOutput("err_sticky", 32'(proto_err), 32'h1);
    doReset();
    applyStimulus("udf", 3'b000, 1'b0, 1'b1);
    checkOutput("idle_d_err", 32'(proto_err), 32'h1);

    // Non-owner pressure: watchdog preemption only when enabled.
    doReset();
    irqCount  = 0;
    sawGrant1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus("wd", 3'b011, 1'b0, 1'b0);
      if (timeout_irq === 1'b1) irqCount++;
      if (bus_grnt === 3'b010) sawGrant1 = 1'b1;
    end
`ifdef ARB_TIMEOUT_EN
    checkOutput("wd_irq_seen", 32'(irqCount > 0), 32'h1);
    checkOutput("wd_handover", 32'(sawGrant1), 32'h1);
`else
    checkOutput("wd_no_irq", 32'(irqCount), 32'h0);
    checkOutput("wd_keep", 32'(bus_grnt), 32'h1);
`endif

    // Reset in the middle of a drain with three responses pending.
    doReset();
    applyStimulus("rg", 3'b010, 1'b0, 1'b0);
    repeat (3) applyStimulus("ra", 3'b010, 1'b1, 1'b0);
    applyStimulus("rdrop", 3'b000, 1'b0, 1'b0);
    checkOutput("pre_rst_busy", 32'(bus_busy), 32'h1);
    doReset();
    checkOutput("rst_mid_busy", 32'(bus_busy), 32'h0);
    applyStimulus("rpost", 3'b011, 1'b0, 1'b0);
    checkOutput("post_rst_grant", 32'(bus_grnt), 32'h1);

    // Randomized traffic with occasional protocol violations and resets.
    doReset();
    reqState = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 7) == 0) reqState[b] = ~reqState[b];
      end
      if (mOwned && !mDraining && mOuts < MAXO) a = ($urandom_range(0, 3) == 0);
      else a = ($urandom_range(0, 63) == 0);
      if (mOuts > 0) d = ($urandom_range(0, 2) == 0);
      else d = ($urandom_range(0, 63) == 0);
      applyStimulus("rnd", reqState, a, d);
      if ($urandom_range(0, 399) == 0) doReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
